// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - word-wide req/ack memory port between the refill controller and memory
interface cache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss handler: latch victim, optional writeback, word refill, commit
// Optional dirty-victim writeback is built in when CACHE_WRITEBACK_EN is defined.
module cache_refill_ctrl #(
  parameter int WAY_NUM     = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 24,
  parameter int LINE_WORDS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_req,
  input  logic [TAG_WIDTH-1:0]             miss_tag,
  input  logic [INDEX_WIDTH-1:0]           miss_index,
  input  logic                             way0_replace_en,
  input  logic                             way1_replace_en,
  input  logic                             way2_replace_en,
  input  logic                             way3_replace_en,
  input  logic                             victim_valid,
  input  logic                             victim_dirty,
  input  logic [TAG_WIDTH-1:0]             victim_tag,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] victim_data,
  cache_refill_ctrl_if.master              mem,
  output logic [WAY_NUM-1:0]               refill_we,
  output logic [INDEX_WIDTH-1:0]           refill_index,
  output logic [TAG_WIDTH-1:0]             refill_tag,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] refill_data,
  output logic                             busy,
  output logic                             refill_done
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int BYTE_W = $clog2(DATA_WIDTH/8);
  localparam int LINE_W = LINE_WORDS*DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef CACHE_WRITEBACK_EN
    S_WB     = 2'd1,
`endif
    S_FILL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [WAY_NUM-1:0]     way_q, way_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [TAG_WIDTH-1:0]   vtag_q, vtag_d;
  logic [LINE_W-1:0]      vdata_q, vdata_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [WAY_NUM-1:0]     refill_we_q, refill_we_d;
  logic                   refill_done_q, refill_done_d;
  logic                   busy_q, busy_d;

  logic [WAY_NUM-1:0]     replace_en;
  logic [WAY_NUM-1:0]     victim_way;
  logic                   wb_go;

  assign replace_en = {way3_replace_en, way2_replace_en, way1_replace_en, way0_replace_en};
  assign cnt_inc    = cnt_q + 1'b1;

`ifdef CACHE_WRITEBACK_EN
  assign wb_go = victim_valid & victim_dirty;
`else
  logic unused_victim_flags;
  assign unused_victim_flags = victim_valid ^ victim_dirty;
  assign wb_go = 1'b0;
`endif

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [TAG_WIDTH-1:0]   tag,
    input logic [INDEX_WIDTH-1:0] idx,
    input logic [CNT_W-1:0]       cnt
  );
    word_addr = {tag, idx, cnt, {BYTE_W{1'b0}}};
  endfunction

  // Lowest-numbered asserted enable wins; no enable at all falls back to way0.
  always_comb begin
    victim_way = '0;
    for (int i = WAY_NUM-1; i >= 0; i--) begin
      if (replace_en[i]) begin
        victim_way    = '0;
        victim_way[i] = 1'b1;
      end
    end
    if (replace_en == '0) begin
      victim_way[0] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    way_d         = way_q;
    tag_d         = tag_q;
    index_d       = index_q;
    vtag_d        = vtag_q;
    vdata_d       = vdata_q;
    line_d        = line_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    refill_we_d   = '0;
    refill_done_d = 1'b0;
    busy_d        = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          way_d     = victim_way;
          tag_d     = miss_tag;
          index_d   = miss_index;
          vtag_d    = victim_tag;
          vdata_d   = victim_data;
          line_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
          if (wb_go) begin
`ifdef CACHE_WRITEBACK_EN
            state_d     = S_WB;
`endif
            mem_we_d    = 1'b1;
            mem_addr_d  = word_addr(victim_tag, miss_index, '0);
            mem_wdata_d = victim_data[DATA_WIDTH-1:0];
          end else begin
            state_d     = S_FILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = word_addr(miss_tag, miss_index, '0);
            mem_wdata_d = '0;
          end
        end
      end
`ifdef CACHE_WRITEBACK_EN
      S_WB: begin
        if (mem_req_q && mem.mem_ack) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d       = '0;
            state_d     = S_FILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = word_addr(tag_q, index_q, '0);
            mem_wdata_d = '0;
          end else begin
            cnt_d       = cnt_inc;
            mem_addr_d  = word_addr(vtag_q, index_q, cnt_inc);
            mem_wdata_d = vdata_q[cnt_inc*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
`endif
      S_FILL: begin
        if (mem_req_q && mem.mem_ack) begin
          line_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem.mem_rdata;
          if (cnt_q == LAST_WORD) begin
            cnt_d         = '0;
            state_d       = S_COMMIT;
            mem_req_d     = 1'b0;
            mem_addr_d    = '0;
            refill_we_d   = way_q;
            refill_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = word_addr(tag_q, index_q, cnt_inc);
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      way_q         <= '0;
      tag_q         <= '0;
      index_q       <= '0;
      vtag_q        <= '0;
      vdata_q       <= '0;
      line_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      refill_we_q   <= '0;
      refill_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      way_q         <= way_d;
      tag_q         <= tag_d;
      index_q       <= index_d;
      vtag_q        <= vtag_d;
      vdata_q       <= vdata_d;
      line_q        <= line_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      refill_we_q   <= refill_we_d;
      refill_done_q <= refill_done_d;
      busy_q        <= busy_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign refill_we     = refill_we_q;
  assign refill_done   = refill_done_q;
  assign busy          = busy_q;
  assign refill_index  = index_q;
  assign refill_tag    = tag_q;
  assign refill_data   = line_q;

endmodule
